spram_wb_port: RTL

Wishbone classic slave that acts as the initiator on a single-port synchronous 4Kx16 RAM port (address/data/q/wren/cen, one-cycle read latency, no byte enables). It turns J1 bus cycles into RAM accesses, generates `wb_ack_o`, and implements byte-lane writes as read-modify-write. It sits between the Wishbone interconnect and the `spram4kx16` instance in the SoC top level.

---
 rtl/j1_wb_pkg.sv | 15 +
 rtl/spram_wb_port.sv | 122 ++++++++++++
 2 files changed

// File: rtl/j1_wb_pkg.sv
// Shared Wishbone-side definitions for the J1 SoC memory ports.
// The controller state type and the default word / byte-lane geometry live here.
package j1_wb_pkg;

    localparam int WB_DATA_WIDTH = 16;
    localparam int WB_LANES      = WB_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_DATA = 2'd1,
        RMW_WR  = 2'd2,
        WR_ACK  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/spram_wb_port.sv
// Wishbone classic slave driving a single-port synchronous RAM (1-cycle read latency).
// Byte-lane writes are done as read-modify-write because the RAM has no byte enables.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for a request; launches the RAM access combinationally
//   RD_DATA | RAM q holds the read word; ack and return it
//   RMW_WR  | old word on q; write the lane-merged word back
//   WR_ACK  | write finished (or sel=0); ack
module spram_wb_port
    import j1_wb_pkg::*;
#(
    parameter int size       = 'h1000,
    parameter int addr_width = $clog2(size),
    parameter int data_width = WB_DATA_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic                      wb_we_i,
    input  logic [addr_width-1:0]     wb_adr_i,
    input  logic [data_width/8-1:0]   wb_sel_i,
    input  logic [data_width-1:0]     wb_dat_i,
    output logic [data_width-1:0]     wb_dat_o,
    output logic                      wb_ack_o,
    output logic [addr_width-1:0]     ram_address,
    output logic [data_width-1:0]     ram_data,
    input  logic [data_width-1:0]     ram_q,
    output logic                      ram_wren,
    output logic                      ram_cen
);

    localparam int lanes = data_width / 8;

    wb_state_t state_q;
    wb_state_t state_d;
    logic      request;

    function automatic logic [data_width-1:0] merge_lanes(
        input logic [lanes-1:0]      sel,
        input logic [data_width-1:0] new_word,
        input logic [data_width-1:0] old_word
    );
        logic [data_width-1:0] merged;
        merged = old_word;
        for (int i = 0; i < lanes; i++) begin
            if (sel[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The ack cycle masks the request so a strobe held through ack is not re-taken.
    assign request  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign wb_ack_o = (state_q == RD_DATA) || (state_q == WR_ACK);
    assign wb_dat_o = (state_q == RD_DATA) ? ram_q : '0;

    always_comb begin
        state_d     = state_q;
        ram_cen     = 1'b0;
        ram_wren    = 1'b0;
        ram_address = wb_adr_i;
        ram_data    = wb_dat_i;

        case (state_q)
            IDLE: begin
                if (request) begin
                    if (!wb_we_i) begin
                        ram_cen = 1'b1;
                        state_d = RD_DATA;
                    end else if (&wb_sel_i) begin
                        ram_cen  = 1'b1;
                        ram_wren = 1'b1;
                        state_d  = WR_ACK;
                    end else if (|wb_sel_i) begin
                        ram_cen = 1'b1;
                        state_d = RMW_WR;
                    end else begin
                        state_d = WR_ACK;
                    end
                end
            end
            RD_DATA: begin
                state_d = IDLE;
            end
            RMW_WR: begin
                // A dropped cycle abandons the merge without touching memory.
                if (wb_cyc_i) begin
                    ram_cen  = 1'b1;
                    ram_wren = 1'b1;
                    ram_data = merge_lanes(wb_sel_i, wb_dat_i, ram_q);
                    state_d  = WR_ACK;
                end else begin
                    state_d = IDLE;
                end
            end
            WR_ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset wins over any in-flight access, so nothing reaches the RAM this cycle.
        if (reset) begin
            ram_cen  = 1'b0;
            ram_wren = 1'b0;
        end
    end

endmodule
